// File: rtl/seq_mult_ctl.sv
// seq_mult_ctl: iterative shift-add multiplier with start/busy/done handshake.
// One DW x DW product takes DW+1 clocks from the accept edge: DW RUN cycles of
// conditional add + shift on operand magnitudes, then one SIGN cycle that
// applies the result sign and publishes the product.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        request, sampled only while busy=0
//   signed_mode  1 = two's complement operands, 0 = unsigned; sampled with start
//   abort        synchronous cancel of an in-flight operation (also blocks start in IDLE)
//   multiplier   operand A, latched on the accept edge
//   multiplicand operand B, latched on the accept edge
//   busy         operation in flight
//   done         one-cycle pulse, product updated in the same cycle
//   product      2*DW-bit result, held until the next completion
module seq_mult_ctl #(
    parameter int DW = 8,
    localparam int CW = $clog2(DW) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_mode,
    input  logic            abort,
    input  logic [DW-1:0]   multiplier,
    input  logic [DW-1:0]   multiplicand,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);

    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] count_q;
    logic [DW-1:0] mag_a_q;
    logic [PW-1:0] shb_q;
    logic [PW-1:0] acc_q;
    logic          neg_q;
    logic [PW-1:0] product_q;
    logic          done_q;

    logic [DW-1:0] mag_a;
    logic [DW-1:0] mag_b;
    logic          accept;
    logic          last_iter;

    // |-2^(DW-1)| = 2^(DW-1) still fits in DW unsigned bits, so the plain
    // two's complement negate is exact for every input.
    always_comb begin
        mag_a = multiplier;
        mag_b = multiplicand;
        if (signed_mode && multiplier[DW-1]) begin
            mag_a = ~multiplier + DW'(1);
        end
        if (signed_mode && multiplicand[DW-1]) begin
            mag_b = ~multiplicand + DW'(1);
        end
    end

    assign accept    = (state_q == IDLE) && start && !abort;
    assign last_iter = (count_q == CW'(DW - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath. The magnitude of A is shifted right each RUN cycle so bit 0
    // is always the bit selected by count; count only decides termination.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            mag_a_q   <= '0;
            shb_q     <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        mag_a_q <= mag_a;
                        shb_q   <= {{DW{1'b0}}, mag_b};
                        acc_q   <= '0;
                        count_q <= '0;
                        neg_q   <= signed_mode & (multiplier[DW-1] ^ multiplicand[DW-1]);
                    end
                end
                RUN: begin
                    if (!abort) begin
                        if (mag_a_q[0]) begin
                            acc_q <= acc_q + shb_q;
                        end
                        shb_q   <= shb_q << 1;
                        mag_a_q <= mag_a_q >> 1;
                        count_q <= count_q + CW'(1);
                    end
                end
                SIGN: begin
                    if (!abort) begin
                        // A zero magnitude negates back to zero, so neg=1 with
                        // a zero result never yields a negative-zero pattern.
                        product_q <= neg_q ? (~acc_q + PW'(1)) : acc_q;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctl.sv
// Self-checking bench for seq_mult_ctl: directed DW=8 vector table, abort,
// back-to-back and mid-run reset sequences, plus random DW=16 / DW=3 runs
// against an integer reference model.
module tb_seq_mult_ctl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DW=8 instance
    logic        start8 = 1'b0, sm8 = 1'b0, abort8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    // DW=16 instance
    logic        start16 = 1'b0, sm16 = 1'b0, abort16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;

    // DW=3 instance
    logic        start3 = 1'b0, sm3 = 1'b0, abort3 = 1'b0;
    logic [2:0]  a3 = '0, b3 = '0;
    logic        busy3, done3;
    logic [5:0]  p3;

    seq_mult_ctl #(.DW(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .abort(abort8),
        .multiplier(a8), .multiplicand(b8), .busy(busy8), .done(done8), .product(p8)
    );

    seq_mult_ctl #(.DW(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .abort(abort16),
        .multiplier(a16), .multiplicand(b16), .busy(busy16), .done(done16), .product(p16)
    );

    seq_mult_ctl #(.DW(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .signed_mode(sm3), .abort(abort3),
        .multiplier(a3), .multiplicand(b3), .busy(busy3), .done(done3), .product(p3)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference product of w-bit operands, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sm, input int unsigned w);
        longint sa, sb, p;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];
    vec_t bb[4];

    // One DW=8 operation: operands are scrambled right after the accept edge
    // to prove only the latched copies are used.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input string name);
        int lat;
        @(negedge clk);
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
        check({name, "_busy"}, 64'(busy8), 64'd1);
        lat = 0;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'd9);
        check({name, "_prod"}, 64'(p8), 64'(exp));
        check({name, "_busy_done"}, 64'(busy8), 64'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done8), 64'd0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        logic [63:0] exp;
        int lat;
        exp = ref_mul({16'd0, a}, {16'd0, b}, sm, 16);
        @(negedge clk);
        a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = ~a; b16 = ~b;
        lat = 0;
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("r16_lat", 64'(lat), 64'd17);
        check("r16_prod", 64'(p16), exp);
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic sm);
        logic [63:0] exp;
        int lat;
        exp = ref_mul({29'd0, a}, {29'd0, b}, sm, 3);
        @(negedge clk);
        a3 = a; b3 = b; sm3 = sm; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; a3 = ~a; b3 = ~b;
        lat = 0;
        while (!done3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("r3_lat", 64'(lat), 64'd4);
        check("r3_prod", 64'(p3), exp);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] exp_v;
        int          k, acc_c, ndone;
        logic        pb, pd, seen;

        vecs[0] = '{8'h07, 8'hFD, 1'b1, 16'hFFEB, "s7xm3"};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000, "sm128xm128"};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080, "sm128x127"};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255"};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "sm1xm1"};
        vecs[5] = '{8'h00, 8'hFB, 1'b1, 16'h0000, "s0xm5"};
        vecs[6] = '{8'h01, 8'h01, 1'b1, 16'h0001, "s1x1"};
        vecs[7] = '{8'h80, 8'h02, 1'b0, 16'h0100, "u128x2"};
        vecs[8] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, "s127x127"};
        vecs[9] = '{8'h00, 8'hFB, 1'b0, 16'h0000, "u0x251"};

        bb[0] = '{8'd3,   8'd4,   1'b0, 16'h000C, "bb0"};
        bb[1] = '{8'h80,  8'h80,  1'b1, 16'h4000, "bb1"};
        bb[2] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF, "bb2"};
        bb[3] = '{8'd200, 8'd100, 1'b0, 16'h4E20, "bb3"};

        // Reset state
        #12;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_prod", 64'(p8), 64'd0);
        check("rst_prod16", 64'(p16), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, vecs[i].name);
        end

        // abort in IDLE blocks a simultaneous start
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd3; sm8 = 1'b0; start8 = 1'b1; abort8 = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", 64'(busy8), 64'd0);
        start8 = 1'b0; abort8 = 1'b0;
        @(negedge clk);
        check("idle_abort_busy2", 64'(busy8), 64'd0);
        check("idle_abort_prod", 64'(p8), 64'h0000);

        // abort during the 4th RUN cycle
        op8(8'h07, 8'hFD, 1'b1, 16'hFFEB, "pre_abort");
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd5; sm8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(busy8), 64'd1);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_busy_after", 64'(busy8), 64'd0);
        check("abort_no_done", 64'(done8), 64'd0);
        check("abort_prod_kept", 64'(p8), 64'hFFEB);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        check("abort_no_late_done", 64'(seen), 64'd0);
        check("abort_prod_kept2", 64'(p8), 64'hFFEB);
        op8(8'd5, 8'd5, 1'b0, 16'd25, "after_abort");

        // Back-to-back with start held high; operands change while busy
        k = 0; acc_c = 0; ndone = 0; pb = 1'b0; pd = 1'b0;
        @(negedge clk);
        a8 = bb[0].a; b8 = bb[0].b; sm8 = bb[0].sm; start8 = 1'b1;
        for (int c = 0; c < 100 && ndone < 4; c++) begin
            @(negedge clk);
            if (busy8 && !pb && k < 4) begin
                exp_q.push_back(bb[k].exp);
                acc_c = c;
                k++;
                if (k < 4) begin
                    a8 = bb[k].a; b8 = bb[k].b; sm8 = bb[k].sm;
                end else begin
                    start8 = 1'b0;
                end
            end
            if (done8) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                check("b2b_lat", 64'(c - acc_c), 64'd9);
                check("b2b_prod", 64'(p8), 64'(exp_v));
                check("b2b_single_pulse", 64'(pd), 64'd0);
                ndone++;
            end
            pb = busy8;
            pd = done8;
        end
        start8 = 1'b0;
        check("b2b_count", 64'(ndone), 64'd4);

        // Reset pulsed mid-RUN
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h7F; sm8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy8), 64'd0);
        check("midrst_done", 64'(done8), 64'd0);
        check("midrst_prod", 64'(p8), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("midrst_quiet", 64'(seen), 64'd0);
        check("midrst_prod_after", 64'(p8), 64'd0);

        // Random regressions
        op16(16'h8000, 16'h8000, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        op3(3'b100, 3'b100, 1'b1);
        op3(3'b111, 3'b111, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            op3(3'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
